// File: rtl/jtframe_romarb_pkg.sv
// jtframe_romarb_pkg: shared constants, arbiter state and grant pickers.
// rr_pick and prio_pick work on a fixed 8-bit request vector so one
// function serves every channel count from 1 to 8.
package jtframe_romarb_pkg;

    localparam int SDRAM_AW  = 22;
    localparam int SDRAM_DW  = 32;
    localparam int READY_CNT = 4;
    localparam int MAX_CH    = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Search starts one past the last grant and wraps. Unused upper
    // channels never request, so the wrap behaves as modulo CH.
    function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                  input logic [2:0]        last);
        logic [MAX_CH-1:0] grant;
        logic [2:0]        idx;
        logic              found;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_CH; k++) begin
            idx = last + 3'(k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

    // Highest requesting index wins.
    function automatic logic [MAX_CH-1:0] prio_pick(input logic [MAX_CH-1:0] req);
        logic [MAX_CH-1:0] grant;
        grant = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            if (req[k]) grant = MAX_CH'(1) << k;
        end
        return grant;
    endfunction

endpackage

// File: rtl/jtframe_romarb_slot.sv
// jtframe_romarb_slot: one-word cache entry for a single client channel.
// A grant re-tags the entry and invalidates it; the fill marks it valid.
// The data word is deliberately left alone by reset.
module jtframe_romarb_slot
    import jtframe_romarb_pkg::*;
#(
    parameter int AW = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [AW-1:0]       addr_i,
    input  logic                cs_i,
    input  logic                grant_i,
    input  logic                fill_we_i,
    input  logic [SDRAM_DW-1:0] fill_data_i,
    output logic                ok_o,
    output logic                miss_o,
    output logic [SDRAM_DW-1:0] data_o
);

    logic [AW-1:0]       tag_q, tag_d;
    logic                valid_q, valid_d;
    logic [SDRAM_DW-1:0] data_q, data_d;

    // Next tag/valid/data from grant and fill strobes.
    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (grant_i) begin
            tag_d   = addr_i;
            valid_d = 1'b0;
        end else if (fill_we_i) begin
            valid_d = 1'b1;
        end
        if (fill_we_i) data_d = fill_data_i;
    end

    // Tag and valid registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end

    // Data word survives reset.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign ok_o   = cs_i & valid_q & (tag_q == addr_i);
    assign miss_o = cs_i & ~ok_o;
    assign data_o = data_q;

endmodule

// File: rtl/jtframe_romarb.sv
// jtframe_romarb: CH-channel SDRAM ROM request arbiter, one cached word per
// channel. Define JTFRAME_ROMARB_RR_EN for round-robin arbitration; without
// it the highest-index missing channel wins (object fetcher beats CPU).
//
// state   | meaning
// IDLE    | no request outstanding, waiting for a miss
// BUSY    | request for channel sel_q outstanding until data_rdy
module jtframe_romarb
    import jtframe_romarb_pkg::*;
#(
    parameter int                     CH      = 2,
    parameter int                     AW      = 15,
    parameter logic [CH*SDRAM_AW-1:0] OFFSETS = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   downloading_i,
    input  logic                   loop_rst_i,
    input  logic [CH*AW-1:0]       ch_addr_i,
    input  logic [CH-1:0]          ch_cs_i,
    output logic [CH-1:0]          ch_ok_o,
    output logic [CH*SDRAM_DW-1:0] ch_dout_o,
    output logic                   ready_o,
    output logic                   sdram_req_o,
    input  logic                   sdram_ack_i,
    input  logic                   data_rdy_i,
    input  logic [SDRAM_DW-1:0]    data_read_i,
    output logic [SDRAM_AW-1:0]    sdram_addr_o,
    output logic                   refresh_en_o
);

    logic                 rst_all;
    logic [CH-1:0]        ok, miss, grant, fill;
    arb_state_e           state_q, state_d;
    logic [CH-1:0]        sel_q, sel_d;
    logic                 req_q, req_d;
    logic [SDRAM_AW-1:0]  addr_q, addr_d, grant_addr;
    logic [READY_CNT-1:0] rdy_sr_q, rdy_sr_d;
    logic                 ready_q, refresh_q, refresh_d;
    logic [MAX_CH-1:0]    req8, grant8;
    logic [2:0]           grant_idx;
    logic                 take, fill_we;

    assign rst_all = rst_i | downloading_i | loop_rst_i;

    for (genvar i = 0; i < CH; i++) begin : g_slot
        jtframe_romarb_slot #(.AW(AW)) u_slot (
            .clk_i       (clk_i),
            .rst_i       (rst_all),
            .addr_i      (ch_addr_i[i*AW +: AW]),
            .cs_i        (ch_cs_i[i]),
            .grant_i     (grant[i]),
            .fill_we_i   (fill[i]),
            .fill_data_i (data_read_i),
            .ok_o        (ok[i]),
            .miss_o      (miss[i]),
            .data_o      (ch_dout_o[i*SDRAM_DW +: SDRAM_DW])
        );
    end

    assign fill = {CH{fill_we}} & sel_q;

`ifdef JTFRAME_ROMARB_RR_EN
    logic [2:0] last_q, last_d;

    // Round-robin pointer follows every grant.
    always_comb begin
        last_d = take ? grant_idx : last_q;
    end

    // Pointer starts at CH-1 so channel 0 goes first after reset.
    always_ff @(posedge clk_i) begin
        if (rst_all) last_q <= 3'(CH-1);
        else         last_q <= last_d;
    end
`endif

    // Candidate grant among misses not already being served.
    always_comb begin
        req8 = MAX_CH'(miss & ~sel_q);
`ifdef JTFRAME_ROMARB_RR_EN
        grant8 = rr_pick(req8, last_q);
`else
        grant8 = prio_pick(req8);
`endif
    end

    // One-hot grant to index and the matching SDRAM address.
    always_comb begin
        grant_idx  = '0;
        grant_addr = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            if (grant8[k]) grant_idx = 3'(k);
        end
        for (int i = 0; i < CH; i++) begin
            if (grant_idx == 3'(i))
                grant_addr = OFFSETS[i*SDRAM_AW +: SDRAM_AW]
                           + SDRAM_AW'({ch_addr_i[i*AW +: AW], 1'b0});
        end
    end

    // Arbiter next state: fill on data_rdy and grant the next miss in the same edge.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        req_d   = req_q;
        addr_d  = addr_q;
        grant   = '0;
        take    = 1'b0;
        fill_we = 1'b0;
        if (sdram_ack_i) req_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|grant8) take = 1'b1;
            end
            ST_BUSY: begin
                if (data_rdy_i) begin
                    fill_we = ~rst_all;
                    if (|grant8) begin
                        take = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        sel_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (take) begin
            state_d = ST_BUSY;
            grant   = grant8[CH-1:0];
            sel_d   = grant8[CH-1:0];
            req_d   = 1'b1;
            addr_d  = grant_addr;
        end
    end

    // Arbiter registers; any reset source abandons the outstanding request.
    always_ff @(posedge clk_i) begin
        if (rst_all) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    assign rdy_sr_d  = {rdy_sr_q[READY_CNT-2:0], 1'b1};
    assign refresh_d = &(~ch_cs_i | ok);

    // Ready delay shift counter and registered refresh permission.
    always_ff @(posedge clk_i) begin
        if (rst_all) begin
            rdy_sr_q  <= '0;
            ready_q   <= 1'b0;
            refresh_q <= 1'b0;
        end else begin
            rdy_sr_q  <= rdy_sr_d;
            ready_q   <= rdy_sr_q[READY_CNT-1];
            refresh_q <= refresh_d;
        end
    end

    assign ch_ok_o      = ok;
    assign ready_o      = ready_q;
    assign sdram_req_o  = req_q;
    assign sdram_addr_o = addr_q;
    assign refresh_en_o = refresh_q;

endmodule

// File: tb/tb_jtframe_romarb.sv
// tb_jtframe_romarb: directed scenarios for the ROM arbiter. Expected SDRAM
// request addresses go into a queue when the miss is created; a monitor pops
// and compares on every new sdram_req.
module tb_jtframe_romarb;

    localparam int CH = 2;
    localparam int AW = 15;
    localparam logic [CH*22-1:0] OFFS = {22'd16384, 22'd0};

    logic             clk = 1'b0;
    logic             rst, downloading, loop_rst, sdram_ack, data_rdy;
    logic [31:0]      data_read;
    logic [CH*AW-1:0] ch_addr;
    logic [CH-1:0]    ch_cs, ch_ok;
    logic [CH*32-1:0] ch_dout;
    logic             ready, sdram_req, refresh_en;
    logic [21:0]      sdram_addr;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [21:0] exp_q[$];
    logic        prev_req = 1'b0;
    int          first;

    always #5 clk = ~clk;

    jtframe_romarb #(.CH(CH), .AW(AW), .OFFSETS(OFFS)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .downloading_i (downloading),
        .loop_rst_i    (loop_rst),
        .ch_addr_i     (ch_addr),
        .ch_cs_i       (ch_cs),
        .ch_ok_o       (ch_ok),
        .ch_dout_o     (ch_dout),
        .ready_o       (ready),
        .sdram_req_o   (sdram_req),
        .sdram_ack_i   (sdram_ack),
        .data_rdy_i    (data_rdy),
        .data_read_i   (data_read),
        .sdram_addr_o  (sdram_addr),
        .refresh_en_o  (refresh_en)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: every new request must match the queue head.
    always @(negedge clk) begin
        if (sdram_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_req: got addr %0h, expected no request", sdram_addr);
            end else begin
                check("req_addr", 64'(sdram_addr), 64'(exp_q.pop_front()));
            end
        end
        prev_req = sdram_req;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!sdram_req && n < 40) begin
            tick();
            n++;
        end
        check(name, 64'(sdram_req), 64'd1);
    endtask

    task automatic serve(input string name, input logic [31:0] d);
        wait_req(name);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        tick();
        data_rdy  = 1'b1;
        data_read = d;
        tick();
        data_rdy  = 1'b0;
    endtask

    task automatic do_reset(input bit chk_ready);
        rst = 1'b1; downloading = 1'b0; loop_rst = 1'b0;
        ch_cs = '0; ch_addr = '0; sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        tick(3);
        if (chk_ready) begin
            check("rst_req",     64'(sdram_req),  64'd0);
            check("rst_addr",    64'(sdram_addr), 64'd0);
            check("rst_ok",      64'(ch_ok),      64'd0);
            check("rst_ready",   64'(ready),      64'd0);
            check("rst_refresh", 64'(refresh_en), 64'd0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (chk_ready) begin
                check($sformatf("ready_clk%0d", k), 64'(ready), 64'(k == 5));
                if (k == 1) check("refresh_idle", 64'(refresh_en), 64'd1);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release and ready timing
        do_reset(1'b1);

        // Single miss, fill, hit
        ch_addr[0 +: AW] = 15'h10;
        ch_cs = 2'b01;
        exp_q.push_back(22'h20);
        tick();
        check("t2_req_next",     64'(sdram_req),  64'd1);
        check("t2_addr",         64'(sdram_addr), 64'h20);
        check("t2_refresh_miss", 64'(refresh_en), 64'd0);
        serve("t2_req", 32'hDEADBEEF);
        check("t2_ok",   64'(ch_ok[0]),      64'd1);
        check("t2_dout", 64'(ch_dout[31:0]), 64'hDEADBEEF);
        tick(3);
        check("t2_noreq",       64'(sdram_req),  64'd0);
        check("t2_refresh_hit", 64'(refresh_en), 64'd1);
        ch_cs = 2'b00;
        tick();
        ch_cs = 2'b01;
        @(negedge clk);
        check("t2_hit_same_cycle", 64'(ch_ok[0]), 64'd1);
        tick(2);

        // Both channels miss together, two rounds
        do_reset(1'b0);
`ifdef JTFRAME_ROMARB_RR_EN
        first = 0;
        exp_q.push_back(22'h20);   exp_q.push_back(22'h400A);
        exp_q.push_back(22'h22);   exp_q.push_back(22'h400C);
`else
        first = 1;
        exp_q.push_back(22'h400A); exp_q.push_back(22'h20);
        exp_q.push_back(22'h400C); exp_q.push_back(22'h22);
`endif
        ch_addr[0 +: AW]  = 15'h10;
        ch_addr[AW +: AW] = 15'h5;
        ch_cs = 2'b11;
        tick();
        check("t3_req", 64'(sdram_req), 64'd1);
        serve("t3_req_a", 32'h11111111);
        check("t3_b2b_req",  64'(sdram_req),    64'd1);
        check("t3_first_ok", 64'(ch_ok[first]), 64'd1);
        check("t3_refresh_partial", 64'(refresh_en), 64'd0);
        serve("t3_req_b", 32'h22222222);
        check("t3_both_ok",     64'(ch_ok), 64'h3);
        check("t3_dout_first",  64'(ch_dout[first*32 +: 32]),     64'h11111111);
        check("t3_dout_second", 64'(ch_dout[(1-first)*32 +: 32]), 64'h22222222);
        ch_addr[0 +: AW]  = 15'h11;
        ch_addr[AW +: AW] = 15'h6;
        serve("t3_req_c", 32'h33333333);
        serve("t3_req_d", 32'h44444444);
        check("t3_r2_ok",    64'(ch_ok), 64'h3);
        check("t3_r2_dout",  64'(ch_dout[first*32 +: 32]), 64'h33333333);
        tick();
        check("t3_refresh_all_hit", 64'(refresh_en), 64'd1);

        // Address change while the request is in flight
        do_reset(1'b0);
        ch_addr[0 +: AW] = 15'h10;
        ch_cs = 2'b01;
        exp_q.push_back(22'h20);
        wait_req("t4_req");
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        ch_addr[0 +: AW] = 15'h11;
        exp_q.push_back(22'h22);
        tick();
        data_rdy = 1'b1;
        data_read = 32'hCAFE0001;
        tick();
        data_rdy = 1'b0;
        check("t4_ok_stale",   64'(ch_ok[0]),      64'd0);
        check("t4_dout_stale", 64'(ch_dout[31:0]), 64'hCAFE0001);
        serve("t4_rereq", 32'h0BADF00D);
        check("t4_ok",   64'(ch_ok[0]),      64'd1);
        check("t4_dout", 64'(ch_dout[31:0]), 64'h0BADF00D);

        // Download pulse mid-request, then a stray data_rdy
        do_reset(1'b0);
        ch_addr[0 +: AW] = 15'h10;
        ch_cs = 2'b01;
        exp_q.push_back(22'h20);
        wait_req("t5_req");
        downloading = 1'b1;
        ch_cs = 2'b00;
        tick();
        check("t5_req_cleared", 64'(sdram_req), 64'd0);
        check("t5_ready_low",   64'(ready),     64'd0);
        downloading = 1'b0;
        tick();
        data_rdy = 1'b1;
        data_read = 32'hFFFF0000;
        tick();
        data_rdy = 1'b0;
        ch_cs = 2'b01;
        exp_q.push_back(22'h20);
        @(negedge clk);
        check("t5_ok_after_stray", 64'(ch_ok[0]), 64'd0);
        tick();
        serve("t5_rereq", 32'h12345678);
        check("t5_ok",   64'(ch_ok[0]),      64'd1);
        check("t5_dout", 64'(ch_dout[31:0]), 64'h12345678);

        tick(3);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
